nms_stage: RTL



---
 rtl/canny_pkg.sv | 36 +++
 rtl/nms_stage_if.sv | 33 +++
 rtl/nms_line_buffer.sv | 23 ++
 rtl/nms_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared types for the camera edge pipeline (gradient/angle pixels, classes).
// Constants: GRDSIZE, ANGSIZE; types: angle_e, nms_pix_t, class_e.
package canny_pkg;

  localparam int GRDSIZE = 8;
  localparam int ANGSIZE = 2;

  typedef enum logic [ANGSIZE-1:0] {
    ANG_NS       = ANGSIZE'(0),
    ANG_DIAG_POS = ANGSIZE'(1),
    ANG_WE       = ANGSIZE'(2),
    ANG_DIAG_NEG = ANGSIZE'(3)
  } angle_e;

  typedef struct packed {
    logic [GRDSIZE-1:0] grad;
    angle_e             angle;
  } nms_pix_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_WEAK   = 2'd1,
    CLS_STRONG = 2'd2
  } class_e;

  function automatic class_e nms_classify(
    input logic [GRDSIZE-1:0] g,
    input logic [GRDSIZE-1:0] lo,
    input logic [GRDSIZE-1:0] hi
  );
    if (g >= hi) return CLS_STRONG;
    if (g >= lo) return CLS_WEAK;
    return CLS_NONE;
  endfunction

endpackage

// File: rtl/nms_stage_if.sv
// Streaming bus of the NMS stage: input beat {valid,sof,grad,angle}, output
// beat {valid,sof,grad[,class]}. master = source/sink side, slave = the stage.
interface nms_stage_if;
  import canny_pkg::*;

  logic               i_valid;
  logic               i_sof;
  logic [GRDSIZE-1:0] i_grad;
  logic [ANGSIZE-1:0] i_angle;
  logic               o_valid;
  logic               o_sof;
  logic [GRDSIZE-1:0] o_grad;
`ifdef NMS_CLASSIFY_EN
  logic [1:0]         o_class;
`endif

  modport master (
    output i_valid, i_sof, i_grad, i_angle,
`ifdef NMS_CLASSIFY_EN
    input  o_class,
`endif
    input  o_valid, o_sof, o_grad
  );

  modport slave (
    input  i_valid, i_sof, i_grad, i_angle,
`ifdef NMS_CLASSIFY_EN
    output o_class,
`endif
    output o_valid, o_sof, o_grad
  );

endinterface

// File: rtl/nms_line_buffer.sv
// One-line {grad,angle} buffer, read-before-write on a write enable.
// Ports: clk, we, addr, wdata -> rdata (old content at addr).
module nms_line_buffer
  import canny_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  nms_pix_t                 wdata,
  output nms_pix_t                 rdata
);

  nms_pix_t mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/nms_stage.sv
// Streaming non-maximum suppression over a 3x3 window; optional NMS_CLASSIFY_EN
// adds o_class. Ports: i_clk, i_rst (async high), bus (nms_stage_if.slave).
module nms_stage
  import canny_pkg::*;
#(
  parameter int IMG_WIDTH = 640
`ifdef NMS_CLASSIFY_EN
  , parameter int LOW_THR  = 20
  , parameter int HIGH_THR = 50
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  nms_stage_if.slave bus
);

  localparam int            CW   = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);

  logic [CW-1:0] col, c;
  logic [1:0]    row, r;
  logic          beat;
  nms_pix_t      pin, rd1, rd2;

  assign beat = bus.i_valid;
  assign pin  = '{grad: bus.i_grad, angle: angle_e'(bus.i_angle)};

  // start of frame restarts the position on this very beat
  always_comb begin
    c = col;
    r = row;
    if (bus.i_sof) begin
      c = '0;
      r = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (beat) begin
      if (c == LAST) begin
        col <= '0;
        row <= (r == 2'd2) ? r : r + 2'd1;
      end else begin
        col <= c + CW'(1);
        row <= r;
      end
    end
  end

  nms_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk   (i_clk),
    .we    (beat),
    .addr  (c),
    .wdata (pin),
    .rdata (rd1)
  );

  nms_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
    .clk   (i_clk),
    .we    (beat),
    .addr  (c),
    .wdata (rd1),
    .rdata (rd2)
  );

  // *_0 holds column c-1, *_1 column c-2; column c is live this beat
  logic [GRDSIZE-1:0] top_0, top_1, mid_1, bot_0, bot_1;
  nms_pix_t           mid_0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      top_0 <= '0;
      top_1 <= '0;
      mid_0 <= '0;
      mid_1 <= '0;
      bot_0 <= '0;
      bot_1 <= '0;
    end else if (beat) begin
      top_1 <= top_0;
      top_0 <= rd2.grad;
      mid_1 <= mid_0.grad;
      mid_0 <= rd1;
      bot_1 <= bot_0;
      bot_0 <= pin.grad;
    end
  end

  logic [GRDSIZE-1:0] nb_a, nb_b, kept;
  logic               emit, border, first;

  always_comb begin
    nb_a = '0;
    nb_b = '0;
    unique case (mid_0.angle)
      ANG_NS: begin
        nb_a = top_0;
        nb_b = bot_0;
      end
      ANG_DIAG_POS: begin
        nb_a = top_1;
        nb_b = pin.grad;
      end
      ANG_WE: begin
        nb_a = mid_1;
        nb_b = rd1.grad;
      end
      ANG_DIAG_NEG: begin
        nb_a = rd2.grad;
        nb_b = bot_1;
      end
    endcase
  end

  assign emit   = beat && (r != 2'd0) && (c != '0);
  assign border = (r == 2'd1) || (c == CW'(1));
  assign first  = (r == 2'd1) && (c == CW'(1));
  // strict on A, inclusive on B: a plateau keeps exactly one side
  assign kept   = (!border && mid_0.grad > nb_a && mid_0.grad >= nb_b)
                ? mid_0.grad : '0;

  logic               ovalid, osof;
  logic [GRDSIZE-1:0] ograd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovalid <= 1'b0;
      osof   <= 1'b0;
      ograd  <= '0;
    end else begin
      ovalid <= emit;
      osof   <= emit && first;
      if (emit) ograd <= kept;
    end
  end

  assign bus.o_valid = ovalid;
  assign bus.o_sof   = osof;
  assign bus.o_grad  = ograd;

`ifdef NMS_CLASSIFY_EN
  logic [1:0] oclass;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      oclass <= '0;
    end else if (emit) begin
      oclass <= nms_classify(kept, GRDSIZE'(LOW_THR), GRDSIZE'(HIGH_THR));
    end
  end

  assign bus.o_class = oclass;
`endif

  // the r-2 angle only travels through the buffer
  logic unused_ang;
  assign unused_ang = ^rd2.angle;

endmodule
